// File: rtl/dpwm_deadtime_cmp.sv
// dpwm_deadtime_cmp: duty comparator plus complementary gate drive with dead time.
// Takes the stepped period counter, holds a double-buffered duty command that is
// swapped in at the period boundary, forms a raw PWM and drives a high/low pair
// that never overlaps. A counter value above the terminal count latches a fault.
module dpwm_deadtime_cmp #(
  parameter int MAX_COUNT  = 1000,
  parameter int DEAD_CYC   = 2,
  parameter int DUTY_RESET = 0
) (
  input  logic       clkFC,
  input  logic       reset,
  input  logic [9:0] cuenta10,
  input  logic [9:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       pwm_h,
  output logic       pwm_l,
  output logic       period_tick,
  output logic       fault
);

  localparam logic [9:0] MAX_C     = 10'(MAX_COUNT);
  localparam logic [9:0] DUTY_RST  = 10'(DUTY_RESET);
  localparam logic [3:0] DCNT_LAST = 4'(DEAD_CYC - 1);

  typedef enum logic [2:0] {
    LOW_ON,
    DEAD_LH,
    HIGH_ON,
    DEAD_HL,
    FAULT
  } state_t;

  logic [9:0] pendQ;
  logic       pendFlagQ;
  logic [9:0] dutyActQ;
  logic       pwmRawQ;
  logic       periodTickQ;
  logic       faultQ;
  state_t     stateQ, stateD;
  logic [3:0] dcntQ, dcntD;

  logic       accept;
  logic       atBoundary;
  logic       rangeErr;
  logic       loadDuty;
  logic [9:0] dutyClamped;

  assign duty_ready  = !pendFlagQ && !faultQ;
  assign accept      = duty_valid && duty_ready;
  assign atBoundary  = (cuenta10 == MAX_C);
  assign rangeErr    = (cuenta10 > MAX_C);
  assign loadDuty    = atBoundary && pendFlagQ;
  assign dutyClamped = (duty_in > MAX_C) ? MAX_C : duty_in;
  assign period_tick = periodTickQ;
  assign fault       = faultQ;

  // Duty double buffer, raw compare, boundary tick and the sticky fault flag.
  always_ff @(posedge clkFC or posedge reset) begin
    if (reset) begin
      pendQ       <= '0;
      pendFlagQ   <= 1'b0;
      dutyActQ    <= DUTY_RST;
      pwmRawQ     <= 1'b0;
      periodTickQ <= 1'b0;
      faultQ      <= 1'b0;
    end else begin
      periodTickQ <= atBoundary;
      pwmRawQ     <= (dutyActQ >= MAX_C) ? 1'b1 : (cuenta10 < dutyActQ);
      if (accept) begin
        pendQ <= dutyClamped;
      end
      if (loadDuty) begin
        dutyActQ <= pendQ;
      end
      if (rangeErr) begin
        faultQ    <= 1'b1;
        pendFlagQ <= 1'b0;
      end else if (accept) begin
        pendFlagQ <= 1'b1;
      end else if (loadDuty) begin
        pendFlagQ <= 1'b0;
      end
    end
  end

  // Dead-time state register; reset parks in DEAD_HL so the low side comes up first.
  always_ff @(posedge clkFC or posedge reset) begin
    if (reset) begin
      stateQ <= DEAD_HL;
      dcntQ  <= '0;
    end else begin
      stateQ <= stateD;
      dcntQ  <= dcntD;
    end
  end

  // Next state: a raw edge opens a dead gap, reversal aborts it, range error wins all.
  always_comb begin
    stateD = stateQ;
    dcntD  = dcntQ;
    if (rangeErr) begin
      stateD = FAULT;
      dcntD  = '0;
    end else begin
      case (stateQ)
        LOW_ON: begin
          if (pwmRawQ) begin
            stateD = DEAD_LH;
            dcntD  = '0;
          end
        end
        DEAD_LH: begin
          if (!pwmRawQ) begin
            stateD = LOW_ON;
          end else if (dcntQ == DCNT_LAST) begin
            stateD = HIGH_ON;
          end else begin
            dcntD = dcntQ + 4'd1;
          end
        end
        HIGH_ON: begin
          if (!pwmRawQ) begin
            stateD = DEAD_HL;
            dcntD  = '0;
          end
        end
        DEAD_HL: begin
          if (pwmRawQ) begin
            stateD = HIGH_ON;
          end else if (dcntQ == DCNT_LAST) begin
            stateD = LOW_ON;
          end else begin
            dcntD = dcntQ + 4'd1;
          end
        end
        FAULT: begin
          stateD = FAULT;
        end
        default: begin
          stateD = FAULT;
        end
      endcase
    end
  end

  // Gate drives decoded from the state register alone, so they cannot overlap.
  always_comb begin
    pwm_h = 1'b0;
    pwm_l = 1'b0;
    case (stateQ)
      LOW_ON:  pwm_l = 1'b1;
      HIGH_ON: pwm_h = 1'b1;
      default: begin
        pwm_h = 1'b0;
        pwm_l = 1'b0;
      end
    endcase
  end

endmodule
